cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter INDEX_W, default 6, set-index width (64 sets).
REQ-002 SHALL have parameter TAG_W, default 10, tag width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rd_en  input  1  MEM-stage load request.
REQ-006 SHALL have port wr_en  input  1  MEM-stage store request.
REQ-007 SHALL have port address  input  32  data byte address; bits [1:0] ignored, [2] word offset, [2+INDEX_W:3] index, next TAG_W bits tag, rest ignored.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port rdata  output  32  load data, valid when ready=1 and rd_en=1.
REQ-010 SHALL have port ready  output  1  request complete; 0 freezes the pipeline.
REQ-011 SHALL have port sram_rd_en  output  1  block-read request to SRAM controller.
REQ-012 SHALL have port sram_wr_en  output  1  word-write request to SRAM controller.
REQ-013 SHALL have port sram_address  output  32  SRAM request address.
REQ-014 SHALL have port sram_wdata  output  32  SRAM write data (= wdata).
REQ-015 SHALL have port sram_rdata  input  64  block read data; [31:0] word 0, [63:32] word 1.
REQ-016 SHALL have port sram_ready  input  1  SRAM controller completion pulse.

Function
REQ-017 SHALL be 2-way set-associative, 2^INDEX_W sets, per way: valid, TAG_W tag, two 32-bit words; one LRU bit per set naming the way to replace next.
REQ-018 SHALL have FSM states IDLE, READ_MISS, WRITE; Moore outputs: sram_rd_en=1 only in READ_MISS, sram_wr_en=1 only in WRITE.
REQ-019 Hit in way w SHALL mean valid[w][index] and tag[w][index]==address tag; hit in both ways impossible by construction.
REQ-020 IDLE, no request: ready=1, no state change.
REQ-021 IDLE, read hit: ready=1 combinationally same cycle, rdata=selected word of hit way; at edge LRU[index]=other way; stay IDLE.
REQ-022 IDLE, read miss: ready=0; next state READ_MISS.
REQ-023 READ_MISS: sram_address={address[31:3],3'b000}; ready=0 while sram_ready=0; cycle sram_ready=1: ready=1, rdata=word of sram_rdata chosen by address[2]; at edge fill way LRU[index] with sram_rdata, set valid and tag, LRU[index]=other way, go IDLE.
REQ-024 IDLE, any write: ready=0; next state WRITE.
REQ-025 WRITE: sram_address=address, sram_wdata=wdata; ready=0 until sram_ready=1; on sram_ready cycle ready=1; at edge go IDLE; if hit, update addressed word of hit way and set LRU[index]=other way; if miss, no allocation (write-through, no-write-allocate).
REQ-026 rd_en and wr_en both high SHALL be treated as a write.
REQ-027 Requester holds rd_en, wr_en, address, wdata stable while ready=0; the block SHALL sample them each cycle (no input latching).
REQ-028 sram_ready asserted in IDLE SHALL be ignored.
REQ-029 Total miss/write latency SHALL be 1 + SRAM controller latency cycles; hit latency 0 extra cycles.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, all valid bits 0, all LRU bits 0, sram_rd_en=0, sram_wr_en=0.
REQ-031 During reset ready SHALL read 1 with no request, and rdata/sram_address/sram_wdata follow combinational rules; data/tag arrays need not reset.
REQ-032 Reset mid READ_MISS or WRITE SHALL abandon the operation with no array update.

Verification
REQ-033 After reset, rd_en=1 address=0x00000104 -> ready=0, next cycle sram_rd_en=1 sram_address=0x00000100; sram_ready with sram_rdata=0xBBBBBBBB_AAAAAAAA -> rdata=0xBBBBBBBB, ready=1.
REQ-034 Repeat read 0x00000100 -> ready=1 same cycle, rdata=0xAAAAAAAA, sram_rd_en stays 0.
REQ-035 Three reads mapping set 0 with tags 1,2,1 then tag 3 -> tag 3 evicts tag 2; subsequent read tag 1 hits, tag 2 misses.
REQ-036 Write 0x12345678 to cached 0x00000100 -> sram_wr_en=1 until sram_ready, then read 0x00000100 hits returning 0x12345678; write to uncached address -> later read misses.
REQ-037 Assert rst=0 while in READ_MISS -> sram_rd_en drops asynchronously; after release, prior miss address still misses.
REQ-038 rd_en=wr_en=1 -> WRITE entered, sram_rd_en never asserted.

Source files
------------

// File: rtl/cache_controller.sv
// 2-way set-associative write-through data cache with block fill from the SRAM controller.
// Read hits complete in the request cycle; misses and writes stall (ready=0) for 1 + SRAM latency cycles.
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int SETS = 1 << INDEX_W;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] READ_MISS = 2'd1;
    localparam logic [1:0] WRITE     = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [63:0]      data_q  [2][SETS];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               word_sel;
    logic               hit0, hit1, hit, hit_way;
    logic [63:0]        hit_blk;
    logic               fill, rd_hit_upd, wr_hit_upd;

    assign index    = address[2+INDEX_W:3];
    assign tag      = address[3+INDEX_W +: TAG_W];
    assign word_sel = address[2];

    assign hit0    = valid_q[0][index] && (tag_q[0][index] == tag);
    assign hit1    = valid_q[1][index] && (tag_q[1][index] == tag);
    assign hit     = hit0 || hit1;
    assign hit_way = hit1;
    assign hit_blk = data_q[hit_way][index];

    assign fill       = (state_q == READ_MISS) && sram_ready;
    assign rd_hit_upd = (state_q == IDLE) && rd_en && !wr_en && hit;
    assign wr_hit_upd = (state_q == WRITE) && sram_ready && hit;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        rdata   = word_sel ? hit_blk[63:32] : hit_blk[31:0];
        case (state_q)
            IDLE: begin
                // a simultaneous rd_en/wr_en is handled as a write
                if (wr_en)
                    state_d = WRITE;
                else if (rd_en && !hit)
                    state_d = READ_MISS;
                else
                    ready = 1'b1;
            end
            READ_MISS: begin
                rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sram_rd_en   = (state_q == READ_MISS);
    assign sram_wr_en   = (state_q == WRITE);
    assign sram_address = (state_q == READ_MISS) ? {address[31:3], 3'b000} : address;
    assign sram_wdata   = wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            lru_q      <= '0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
        end else begin
            state_q <= state_d;
            if (fill) begin
                valid_q[lru_q[index]][index] <= 1'b1;
                lru_q[index]                 <= ~lru_q[index];
            end else if (rd_hit_upd || wr_hit_upd) begin
                lru_q[index] <= ~hit_way;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (rst && fill) begin
            tag_q[lru_q[index]][index]  <= tag;
            data_q[lru_q[index]][index] <= sram_rdata;
        end else if (rst && wr_hit_upd) begin
            if (word_sel)
                data_q[hit_way][index][63:32] <= wdata;
            else
                data_q[hit_way][index][31:0]  <= wdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench: a recency-ordered per-set tag list plus a flat word memory predict hit/miss and data.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [63:0] sram_rdata;
    logic        sram_ready;

    int n_checks = 0;
    int n_errors = 0;

    typedef logic [9:0] tagq_t[$];
    tagq_t             sets_m [64];
    logic [31:0]       mem_m  [logic [29:0]];

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .wr_en        (wr_en),
        .address      (address),
        .wdata        (wdata),
        .rdata        (rdata),
        .ready        (ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] wa);
        if (mem_m.exists(wa))
            return mem_m[wa];
        return {wa, 2'b00} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic int find_way(input int s, input logic [9:0] t);
        for (int i = 0; i < sets_m[s].size(); i++)
            if (sets_m[s][i] == t)
                return i;
        return -1;
    endfunction

    task automatic touch(input int s, input int pos);
        logic [9:0] t;
        t = sets_m[s][pos];
        sets_m[s].delete(pos);
        sets_m[s].push_front(t);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++)
            sets_m[i].delete();
    endtask

    // One request from the pipeline; the bench plays the SRAM controller.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] got_rd,
                          output logic got_hit);
        int         s;
        logic [9:0] t;
        int         pos;
        int         lat;
        logic       wr_op;
        logic       exp_hit;
        s       = int'(addr[8:3]);
        t       = addr[18:9];
        pos     = find_way(s, t);
        exp_hit = (pos >= 0);
        wr_op   = wr;
        rd_en   = rd;
        wr_en   = wr;
        address = addr;
        wdata   = data;
        @(negedge clk);
        got_hit = ready;
        got_rd  = rdata;
        if (!wr_op && exp_hit) begin
            chk("hit_rdy", ready, 1);
            chk("hit_dat", rdata, mem_rd(addr[31:2]));
            chk("hit_rden", sram_rd_en, 0);
            @(posedge clk); #1;
            touch(s, pos);
        end else begin
            chk("req_rdy", ready, 0);
            @(posedge clk); #1;
            lat = $urandom_range(0, 3);
            repeat (lat) begin
                @(negedge clk);
                chk("wait_rdy", ready, 0);
                chk("wait_rden", sram_rd_en, !wr_op);
                chk("wait_wren", sram_wr_en, wr_op);
                @(posedge clk); #1;
            end
            sram_ready = 1'b1;
            sram_rdata = {mem_rd({addr[31:3], 1'b1}), mem_rd({addr[31:3], 1'b0})};
            @(negedge clk);
            chk("done_rdy", ready, 1);
            chk("done_rden", sram_rd_en, !wr_op);
            chk("done_wren", sram_wr_en, wr_op);
            chk("saddr", sram_address, wr_op ? addr : {addr[31:3], 3'b000});
            if (wr_op)
                chk("swdat", sram_wdata, data);
            else
                chk("miss_dat", rdata, mem_rd(addr[31:2]));
            got_rd = rdata;
            @(posedge clk); #1;
            sram_ready = 1'b0;
            sram_rdata = {$urandom, $urandom};
            if (wr_op) begin
                mem_m[addr[31:2]] = data;
                if (exp_hit)
                    touch(s, pos);
            end else begin
                sets_m[s].push_front(t);
                if (sets_m[s].size() > 2)
                    void'(sets_m[s].pop_back());
            end
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // sram_ready in IDLE must not change anything.
    task automatic idle_cycle();
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        sram_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("idle_rdy", ready, 1);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        @(negedge clk);
        chk("idle_rden", sram_rd_en, 0);
        chk("idle_wren", sram_wr_en, 0);
        @(posedge clk); #1;
    endtask

    logic [31:0] got_d;
    logic        got_h;

    initial begin
        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'h0;
        wdata      = 32'h0;
        sram_rdata = 64'h0;
        sram_ready = 1'b0;
        clear_model();
        #1;
        chk("rst_rdy", ready, 1);
        chk("rst_rden", sram_rd_en, 0);
        chk("rst_wren", sram_wr_en, 0);
        #21 rst = 1'b1;
        @(posedge clk); #1;

        // basic miss then hit on the same block
        mem_m[30'h40] = 32'hAAAAAAAA;
        mem_m[30'h41] = 32'hBBBBBBBB;
        access(1, 0, 32'h0000_0104, 0, got_d, got_h);
        chk("d_miss_hit", got_h, 0);
        chk("d_miss_dat", got_d, 32'hBBBBBBBB);
        access(1, 0, 32'h0000_0100, 0, got_d, got_h);
        chk("d_rehit", got_h, 1);
        chk("d_rehit_dat", got_d, 32'hAAAAAAAA);

        // LRU replacement in set 0: tags 1,2,1 then 3 evicts 2
        access(1, 0, 32'h0000_0200, 0, got_d, got_h);
        access(1, 0, 32'h0000_0400, 0, got_d, got_h);
        access(1, 0, 32'h0000_0200, 0, got_d, got_h);
        chk("lru_t1_hit", got_h, 1);
        access(1, 0, 32'h0000_0600, 0, got_d, got_h);
        chk("lru_t3_miss", got_h, 0);
        access(1, 0, 32'h0000_0200, 0, got_d, got_h);
        chk("lru_t1_keep", got_h, 1);
        access(1, 0, 32'h0000_0400, 0, got_d, got_h);
        chk("lru_t2_gone", got_h, 0);

        // write hit updates the cache, write miss does not allocate
        access(0, 1, 32'h0000_0100, 32'h12345678, got_d, got_h);
        access(1, 0, 32'h0000_0100, 0, got_d, got_h);
        chk("wr_hit_rd", got_h, 1);
        chk("wr_hit_dat", got_d, 32'h12345678);
        access(0, 1, 32'h0000_0808, 32'hCAFEF00D, got_d, got_h);
        access(1, 0, 32'h0000_0808, 0, got_d, got_h);
        chk("wr_noalloc", got_h, 0);
        chk("wr_noalloc_dat", got_d, 32'hCAFEF00D);

        // both enables: handled as a write
        access(1, 1, 32'h0000_0110, 32'h0BADBEEF, got_d, got_h);

        // reset in the middle of a read miss
        rd_en   = 1'b1;
        address = 32'h0000_0A08;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_rden", sram_rd_en, 1);
        #2 rst = 1'b0;
        #1 chk("rm_rst_rden", sram_rd_en, 0);
        rd_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        clear_model();
        @(posedge clk); #1;
        access(1, 0, 32'h0000_0A08, 0, got_d, got_h);
        chk("rm_still_miss", got_h, 0);
        access(1, 0, 32'h0000_0100, 0, got_d, got_h);
        chk("rm_inval", got_h, 0);

        // random traffic over a few sets and tags to exercise eviction
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 11);
            a  = (32'($urandom_range(0, 4)) << 9) | (32'($urandom_range(0, 3)) << 3)
                 | 32'($urandom_range(0, 7));
            if (op < 6)
                access(1, 0, a, 0, got_d, got_h);
            else if (op < 9)
                access(0, 1, a, $urandom, got_d, got_h);
            else if (op < 10)
                access(1, 1, a, $urandom, got_d, got_h);
            else
                idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
